// File: rtl/envelope_sink_fifo_if.sv
// Bundles the envelope sample stream, the CPU read port, and the FIFO
// control/status lines into one port. Clock and reset stay separate.
interface envelope_sink_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] s_axis_data_tdata;
  logic             s_axis_data_tvalid;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             flush;
  logic             clr_ovf;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic [15:0]      drop_count;
  logic             irq;

  // Producer/CPU side: drives the stream, the read strobe and the controls
  modport master (
    output s_axis_data_tdata, s_axis_data_tvalid, rd_en, flush, clr_ovf,
    input  rd_data, rd_valid, count, empty, full, overflow, drop_count, irq
  );

  // FIFO side
  modport slave (
    input  s_axis_data_tdata, s_axis_data_tvalid, rd_en, flush, clr_ovf,
    output rd_data, rd_valid, count, empty, full, overflow, drop_count, irq
  );
endinterface

// File: rtl/envelope_sink_fifo.sv
// Capture FIFO for the decimated envelope stream. The stream has no
// tready, so a beat that finds the FIFO full is dropped and counted
// instead of being stalled. The CPU drains entries with a read strobe and
// gets registered data one cycle later. irq is a level that stays high
// while the fill level is at or above THRESHOLD.
module envelope_sink_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int THRESHOLD = 32
) (
  input logic               aclk,
  input logic               areset,
  envelope_sink_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_count_q, drop_count_d;

  logic empty_w, full_w;
  logic rd_acc, wr_acc, drop;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(DEPTH));

  // flush overrides everything in its cycle. A read on an empty FIFO is not
  // accepted, so a concurrent write then lands without read-through. A read
  // on a full FIFO frees one slot, so the concurrent write is accepted.
  assign rd_acc = bus.rd_en && !empty_w && !bus.flush;
  assign wr_acc = bus.s_axis_data_tvalid && (!full_w || rd_acc) && !bus.flush;
  assign drop   = bus.s_axis_data_tvalid && full_w && !rd_acc && !bus.flush;

  // Next-state for pointers, fill level, read port and overflow tracking
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // A drop in the same cycle as clr_ovf counts as the first drop after the clear
    if (bus.clr_ovf) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (bus.clr_ovf)
        drop_count_d = 16'd1;
      else if (drop_count_q != 16'hFFFF)
        drop_count_d = drop_count_q + 16'd1;
    end
  end

  // State registers; an asynchronous reset discards all buffered samples
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Sample storage; left unreset because stale entries are never readable
  always_ff @(posedge aclk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.s_axis_data_tdata;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.count      = count_q;
  assign bus.empty      = empty_w;
  assign bus.full       = full_w;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;
  assign bus.irq        = (count_q >= CW'(THRESHOLD));
endmodule

// File: tb/tb_envelope_sink_fifo.sv
// Bench for envelope_sink_fifo: directed sequences plus randomized traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_envelope_sink_fifo;
  localparam int WIDTH     = 32;
  localparam int DEPTH     = 64;
  localparam int THRESHOLD = 32;

  logic aclk = 1'b0;
  logic areset;

  envelope_sink_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  envelope_sink_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .THRESHOLD(THRESHOLD)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus.slave)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_q [$];
  logic [31:0] m_rd_data;
  logic        m_rd_valid;
  logic        m_ovf;
  int          m_dc;
  logic [31:0] last_rd;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_dc       = 0;
  endtask

  // One clock of the FIFO as described by its rules, applied to the queue
  task automatic model_cycle(input logic tv, input logic [31:0] td,
                             input logic re, input logic fl, input logic co);
    bit was_full, was_empty, rd, wr, dr;
    was_full   = (m_q.size() == DEPTH);
    was_empty  = (m_q.size() == 0);
    m_rd_valid = 1'b0;
    rd = 0; wr = 0; dr = 0;
    if (fl) begin
      m_q.delete();
    end else begin
      rd = re && !was_empty;
      wr = tv && (!was_full || rd);
      dr = tv && was_full && !rd;
      if (rd) begin
        m_rd_data  = m_q.pop_front();
        m_rd_valid = 1'b1;
      end
      if (wr) m_q.push_back(td);
    end
    if (co) begin
      m_ovf = 1'b0;
      m_dc  = 0;
    end
    if (dr) begin
      m_ovf = 1'b1;
      if (m_dc < 65535) m_dc = m_dc + 1;
    end
  endtask

  task automatic compare_all(input string tag);
    int n;
    n = m_q.size();
    check_val({tag, ".count"},    32'(bus.count),      32'(n));
    check_val({tag, ".empty"},    32'(bus.empty),      32'(n == 0));
    check_val({tag, ".full"},     32'(bus.full),       32'(n == DEPTH));
    check_val({tag, ".irq"},      32'(bus.irq),        32'(n >= THRESHOLD));
    check_val({tag, ".overflow"}, 32'(bus.overflow),   32'(m_ovf));
    check_val({tag, ".drops"},    32'(bus.drop_count), 32'(m_dc));
    check_val({tag, ".rd_valid"}, 32'(bus.rd_valid),   32'(m_rd_valid));
    check_val({tag, ".rd_data"},  bus.rd_data,         m_rd_data);
  endtask

  // Drive one cycle of inputs, let the edge happen, then check 1 ns later
  task automatic step(input string tag, input logic tv, input logic [31:0] td,
                      input logic re, input logic fl, input logic co);
    bus.s_axis_data_tvalid = tv;
    bus.s_axis_data_tdata  = td;
    bus.rd_en              = re;
    bus.flush              = fl;
    bus.clr_ovf            = co;
    @(posedge aclk);
    model_cycle(tv, td, re, fl, co);
    #1;
    if (bus.rd_valid) last_rd = bus.rd_data;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int rv_run;
    areset = 1'b1;
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tdata  = '0;
    bus.rd_en   = 1'b0;
    bus.flush   = 1'b0;
    bus.clr_ovf = 1'b0;
    last_rd = '0;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    compare_all("reset");
    areset = 1'b0;

    // Basic ordering and back-to-back reads
    for (int i = 0; i < 5; i++) step("wr5", 1'b1, 32'h1000 + i, 1'b0, 1'b0, 1'b0);
    rv_run = 0;
    for (int i = 0; i < 5; i++) begin
      step("rd5", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      if (bus.rd_valid && bus.rd_data == 32'h1000 + i) rv_run++;
    end
    check_val("rd5_consecutive", 32'(rv_run), 32'd5);
    check_val("rd5_empty", 32'(bus.empty), 32'd1);

    // Fill, overflow by 3, drain
    for (int i = 0; i < DEPTH + 3; i++) step("fill", 1'b1, 32'h2000 + i, 1'b0, 1'b0, 1'b0);
    check_val("ovf_dc3", 32'(bus.drop_count), 32'd3);
    check_val("ovf_full", 32'(bus.full), 32'd1);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("drain_last", last_rd, 32'h2000 + DEPTH - 1);
    idle("drain_idle");

    // Simultaneous read and write while full
    step("clr", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 32'h3000 + i, 1'b0, 1'b0, 1'b0);
    step("rw_full", 1'b1, 32'hABCD, 1'b1, 1'b0, 1'b0);
    check_val("rw_full_count", 32'(bus.count), 32'(DEPTH));
    check_val("rw_full_nodrop", 32'(bus.drop_count), 32'd0);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("abcd_last", last_rd, 32'hABCD);

    // Threshold crossing
    for (int i = 0; i < THRESHOLD - 1; i++) step("thr", 1'b1, 32'h4000 + i, 1'b0, 1'b0, 1'b0);
    check_val("irq_below", 32'(bus.irq), 32'd0);
    step("thr_hit", 1'b1, 32'h4FFF, 1'b0, 1'b0, 1'b0);
    check_val("irq_at", 32'(bus.irq), 32'd1);
    step("thr_rd", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("irq_after_rd", 32'(bus.irq), 32'd0);
    step("flush0", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Pointer wrap with concurrent traffic
    for (int i = 0; i < 48; i++) step("wrap_w", 1'b1, 32'h5000 + i, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) step("wrap_r", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("wrap_rw", 1'b1, 32'h6000 + i, 1'b1, 1'b0, 1'b0);
    check_val("wrap_count", 32'(bus.count), 32'd1);
    check_val("wrap_nodrop", 32'(bus.drop_count), 32'd0);

    // Flush with a concurrent beat, then clr_ovf concurrent with a drop
    step("flush_tv", 1'b1, 32'h7777, 1'b0, 1'b1, 1'b0);
    check_val("flush_count", 32'(bus.count), 32'd0);
    check_val("flush_dc", 32'(bus.drop_count), 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) step("fill3", 1'b1, 32'h8000 + i, 1'b0, 1'b0, 1'b0);
    step("clr_drop", 1'b1, 32'h8888, 1'b0, 1'b0, 1'b1);
    check_val("clr_drop_ovf", 32'(bus.overflow), 32'd1);
    check_val("clr_drop_dc", 32'(bus.drop_count), 32'd1);

    // Randomized traffic in phases of different write/read pressure
    for (int ph = 0; ph < 4; ph++) begin
      int pw, pr;
      pw = (ph == 0) ? 90 : (ph == 1) ? 30 : (ph == 2) ? 60 : 75;
      pr = (ph == 0) ? 20 : (ph == 1) ? 85 : (ph == 2) ? 60 : 50;
      for (int i = 0; i < 500; i++) begin
        step("rand",
             ($urandom_range(0, 99) < pw),
             $urandom(),
             ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 199) == 0),
             ($urandom_range(0, 99) < 2));
      end
    end

    // Asynchronous reset in the middle of traffic
    for (int i = 0; i < 10; i++) step("pre_rst", 1'b1, 32'h9000 + i, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("pre_rst_f", 1'b1, 32'h9100 + i, 1'b0, 1'b0, 1'b0);
    bus.s_axis_data_tvalid = 1'b1;
    bus.rd_en = 1'b1;
    areset = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge aclk);
    #1;
    compare_all("rst_hold");
    areset = 1'b0;
    step("post_rst_w", 1'b1, 32'hA5A5, 1'b1, 1'b0, 1'b0);
    step("post_rst_r", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    check_val("post_rst_data", bus.rd_data, 32'hA5A5);
    idle("end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
